// File: rtl/boolean_sweep_ctrl.sv
// Boolean sweep controller: steps {a,b,c} through all eight input vectors,
// waits SETTLE cycles per vector, samples func_d, and compares the result
// against a latched golden truth table.
module boolean_sweep_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       func_d,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] captured,
    output logic [3:0] mismatch_count
);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } state_e;

    // Last settle count before moving to SAMPLE
    localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] exp_q, exp_d;
    logic [7:0] cap_q, cap_d;
    logic [3:0] mm_q, mm_d;
    logic       pass_q, pass_d;

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            exp_q   <= 8'h00;
            cap_q   <= 8'h00;
            mm_q    <= 4'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            cap_q   <= cap_d;
            mm_q    <= mm_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state logic for the sweep FSM and its datapath
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        cap_d   = cap_q;
        mm_d    = mm_q;
        pass_d  = pass_q;

        unique case (state_q)
            StIdle: begin
                // abort outranks start, so a simultaneous request is dropped
                if (start && !abort) begin
                    idx_d   = 3'd0;
                    cnt_d   = 4'd0;
                    cap_d   = 8'h00;
                    mm_d    = 4'd0;
                    exp_d   = expected;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (cnt_q == SettleLast) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StSample: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    cap_d[idx_q] = func_d;
                    if (func_d != exp_q[idx_q]) begin
                        mm_d = mm_q + 4'd1;
                    end
                    if (idx_q == 3'd7) begin
                        // Decide pass from the count including this last sample
                        pass_d  = (mm_d == 4'd0);
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        cnt_d   = 4'd0;
                        state_d = StSettle;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Vector drive comes straight from the index register, so it holds in IDLE/DONE
    always_comb begin
        {a, b, c}      = idx_q;
        busy           = (state_q == StSettle) || (state_q == StSample);
        done           = (state_q == StDone);
        pass           = pass_q;
        captured       = cap_q;
        mismatch_count = mm_q;
    end

endmodule

// File: tb/tb_boolean_sweep_ctrl.sv
// Self-checking bench for boolean_sweep_ctrl: a timeline-based model of the
// sweep is compared against the SETTLE=2 instance every cycle, and directed
// scenarios pin done timing, results, abort and reset behaviour. Two extra
// instances cover SETTLE=1 and SETTLE=15.
module tb_boolean_sweep_ctrl;

    localparam int S = 2;
    localparam int P = S + 1;
    localparam int L = 8 * P;

    logic       clk, rst, start, abort, fsel, chk_en;
    logic [7:0] expected;
    logic       func_d, a, b, c, busy, done, pass;
    logic [7:0] captured;
    logic [3:0] mismatch_count;

    logic       start1, func1, a1, b1, c1, busy1, done1, pass1;
    logic [7:0] cap1;
    logic [3:0] mm1;
    logic       start15, func15, a15, b15, c15, busy15, done15, pass15;
    logic [7:0] cap15;
    logic [3:0] mm15;
    logic       abort_off;

    int checks = 0;
    int errors = 0;
    int r_edge, r_cnt;
    logic [2:0] r_abc0;
    logic r_busy0;

    boolean_sweep_ctrl #(.SETTLE(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .expected(expected),
        .func_d(func_d), .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
        .captured(captured), .mismatch_count(mismatch_count)
    );

    boolean_sweep_ctrl #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort_off), .expected(expected),
        .func_d(func1), .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
        .captured(cap1), .mismatch_count(mm1)
    );

    boolean_sweep_ctrl #(.SETTLE(15)) u_dut15 (
        .clk(clk), .rst(rst), .start(start15), .abort(abort_off), .expected(expected),
        .func_d(func15), .a(a15), .b(b15), .c(c15), .busy(busy15), .done(done15),
        .pass(pass15), .captured(cap15), .mismatch_count(mm15)
    );

    always #5 clk = ~clk;

    // Function under control: majority, or the faulty a&b
    function automatic logic fbit(input logic sel, input logic [2:0] v);
        if (sel) return v[2] & v[1];
        return (v[2] & v[1]) | (v[1] & v[0]) | (v[0] & v[2]);
    endfunction

    function automatic logic [7:0] tbl(input logic sel);
        logic [7:0] t;
        for (int v = 0; v < 8; v++) t[v] = fbit(sel, 3'(v));
        return t;
    endfunction

    assign func_d = fbit(fsel, {a, b, c});
    assign func1  = fbit(1'b0, {a1, b1, c1});
    assign func15 = fbit(1'b0, {a15, b15, c15});

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    // Model: a sweep is a timeline of 8*(S+1) cycles after the accepting edge;
    // cycle t drives vector t/(S+1) and samples when t%(S+1)==S.
    logic       m_run, m_done, m_pass;
    int         m_t;
    logic [2:0] m_abc;
    logic [7:0] m_cap, m_exp, m_smask;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run <= 1'b0; m_done <= 1'b0; m_pass <= 1'b0; m_t <= 0;
            m_abc <= 3'd0; m_cap <= 8'h00; m_exp <= 8'h00; m_smask <= 8'h00;
        end else begin
            m_done <= 1'b0;
            if (m_run) begin
                if (abort) begin
                    m_run <= 1'b0;
                end else begin
                    if (m_t % P == S) begin
                        m_cap[m_abc]   <= fbit(fsel, m_abc);
                        m_smask[m_abc] <= 1'b1;
                    end
                    if (m_t == L - 1) begin
                        m_run  <= 1'b0;
                        m_done <= 1'b1;
                        m_pass <= (tbl(fsel) == m_exp);
                    end else begin
                        m_t   <= m_t + 1;
                        m_abc <= 3'((m_t + 1) / P);
                    end
                end
            end else if (!m_done && start && !abort) begin
                m_run <= 1'b1; m_t <= 0; m_abc <= 3'd0;
                m_cap <= 8'h00; m_smask <= 8'h00; m_exp <= expected;
            end
        end
    end

    // Every-cycle comparison of the SETTLE=2 instance against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("abc", int'({a, b, c}), int'(m_abc));
            chk("busy", int'(busy), int'(m_run));
            chk("done", int'(done), int'(m_done));
            chk("pass", int'(pass), int'(m_pass));
            chk("captured", int'(captured), int'(m_cap));
            chk("mismatch_count", int'(mismatch_count),
                $countones((m_cap ^ m_exp) & m_smask));
        end
    end

    task automatic lit_reset();
        chk("rst_abc", int'({a, b, c}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_captured", int'(captured), 0);
        chk("rst_mismatch", int'(mismatch_count), 0);
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start = v;
        else if (sel == 1) start1 = v;
        else start15 = v;
    endtask

    // One start pulse, then a fixed-length observation window. Cycle n is the
    // cycle after the n-th edge following the accepting edge.
    task automatic sweep(input int sel, input int p1, input int p2, input int p3,
                         input int ab_at, input int rs_at, input int lim);
        logic dn;
        r_edge = -1;
        r_cnt  = 0;
        @(negedge clk);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        r_abc0  = (sel == 0) ? {a, b, c} : (sel == 1) ? {a1, b1, c1} : {a15, b15, c15};
        r_busy0 = (sel == 0) ? busy : (sel == 1) ? busy1 : busy15;
        for (int n = 1; n <= lim; n++) begin
            @(negedge clk);
            abort = 1'b0;
            rst   = 1'b0;
            dn = (sel == 0) ? done : (sel == 1) ? done1 : done15;
            if (dn) begin
                r_cnt++;
                if (r_edge < 0) r_edge = n;
            end
            if (sel == 0) start = (n == p1) || (n == p2) || (n == p3);
            if (n == ab_at) abort = 1'b1;
            if (n == rs_at) begin
                #2 rst = 1'b1;
                #1 lit_reset();
            end
        end
        start = 1'b0;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0; start = 1'b0; abort = 1'b0; abort_off = 1'b0;
        start1 = 1'b0; start15 = 1'b0; fsel = 1'b0; expected = 8'hE8; chk_en = 1'b0;
        #3 rst = 1'b1;
        #1 lit_reset();
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Majority function against its own truth table
        sweep(0, -1, -1, -1, -1, -1, 40);
        chk("maj_first_abc", int'(r_abc0), 0);
        chk("maj_first_busy", int'(r_busy0), 1);
        chk("maj_done_edge", r_edge, 24);
        chk("maj_done_cnt", r_cnt, 1);
        chk("maj_captured", int'(captured), 32'hE8);
        chk("maj_mismatch", int'(mismatch_count), 0);
        chk("maj_pass", int'(pass), 1);

        // Faulty a&b: vectors 3 and 5 disagree
        fsel = 1'b1;
        sweep(0, -1, -1, -1, -1, -1, 40);
        chk("ab_done_edge", r_edge, 24);
        chk("ab_done_cnt", r_cnt, 1);
        chk("ab_captured", int'(captured), 32'hC0);
        chk("ab_mismatch", int'(mismatch_count), 2);
        chk("ab_pass", int'(pass), 0);

        // Abort during vector 3: pass keeps the failing result from above
        fsel = 1'b0;
        sweep(0, -1, -1, -1, 10, -1, 40);
        chk("abort_done_cnt", r_cnt, 0);
        chk("abort_pass", int'(pass), 0);
        chk("abort_captured", int'(captured), 0);
        chk("abort_abc_held", int'({a, b, c}), 3);
        chk("abort_busy", int'(busy), 0);

        // abort and start together in IDLE: no sweep
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", int'(busy), 0);

        // Re-pulsed start mid-sweep and during DONE is ignored
        sweep(0, 5, 10, 24, -1, -1, 40);
        chk("restart_done_edge", r_edge, 24);
        chk("restart_done_cnt", r_cnt, 1);
        chk("restart_idle_busy", int'(busy), 0);
        chk("restart_pass", int'(pass), 1);
        sweep(0, -1, -1, -1, -1, -1, 30);
        chk("second_first_abc", int'(r_abc0), 0);
        chk("second_first_busy", int'(r_busy0), 1);
        chk("second_done_edge", r_edge, 24);

        // Reset during vector 4, then a clean full sweep
        sweep(0, -1, -1, -1, -1, 13, 40);
        chk("rst_done_cnt", r_cnt, 0);
        chk("rst_busy_after", int'(busy), 0);
        sweep(0, -1, -1, -1, -1, -1, 40);
        chk("post_rst_done_edge", r_edge, 24);
        chk("post_rst_captured", int'(captured), 32'hE8);
        chk("post_rst_pass", int'(pass), 1);

        // SETTLE=1 and SETTLE=15 builds
        sweep(1, -1, -1, -1, -1, -1, 30);
        chk("s1_done_edge", r_edge, 16);
        chk("s1_done_cnt", r_cnt, 1);
        chk("s1_captured", int'(cap1), 32'hE8);
        chk("s1_pass", int'(pass1), 1);
        sweep(2, -1, -1, -1, -1, -1, 140);
        chk("s15_done_edge", r_edge, 128);
        chk("s15_done_cnt", r_cnt, 1);
        chk("s15_captured", int'(cap15), 32'hE8);
        chk("s15_mismatch", int'(mm15), 0);
        chk("s15_pass", int'(pass15), 1);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
